spi_slave_ctrl_fsm: RTL and testbench

- Parametrised SPI slave control FSM, clocked by the system clock.
- Sequences a command frame (ADDR_W address bits, then 1 R/W bit, MSB first), then one or more DATA_W-bit data frames.
- Drives the enables for the address latch, the parallel-load output shift register, the data memory write, and the MISO tri-state buffer.
- Sits between the input conditioners (synchronised cs_n, one-clk sclk edge pulses) and the shift registers / data memory.

---
 rtl/spi_ctrl_pkg.sv | 30 +++
 rtl/spi_bit_counter.sv | 31 +++
 rtl/spi_slave_ctrl_fsm.sv | 162 ++++++++++++++++
 tb/tb_spi_slave_ctrl_fsm.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_ctrl_pkg.sv
// Shared types and helpers for the SPI slave control FSM: one-hot state
// encoding, default geometry and the bit-counter width function.
package spi_ctrl_pkg;

  localparam int DEF_ADDR_W = 7;
  localparam int DEF_DATA_W = 8;
  localparam int DEF_RD_LAT = 1;
  localparam int LAT_W      = 4;  // holds RD_LAT-1 for RD_LAT up to 15
  localparam int NUM_STATES = 9;

  typedef enum logic [NUM_STATES-1:0] {
    ST_IDLE      = 9'b0_0000_0001,
    ST_CMD       = 9'b0_0000_0010,
    ST_RD_WAIT   = 9'b0_0000_0100,
    ST_RD_LOAD   = 9'b0_0000_1000,
    ST_RD_SHIFT  = 9'b0_0001_0000,
    ST_WR_SHIFT  = 9'b0_0010_0000,
    ST_WR_COMMIT = 9'b0_0100_0000,
    ST_DONE      = 9'b0_1000_0000,
    ST_INC       = 9'b1_0000_0000
  } state_e;

  // Wide enough to count the longer of the command frame and a data frame.
  function automatic int cnt_width(input int addr_w, input int data_w);
    int longest;
    longest = (addr_w + 1 > data_w) ? addr_w + 1 : data_w;
    return $clog2(longest + 1);
  endfunction

endpackage

// File: rtl/spi_bit_counter.sv
// Frame bit counter: synchronous clear has priority over enable; hit_o flags
// that the current count equals the terminal value.
module spi_bit_counter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clear_i,
  input  logic         enable_i,
  input  logic [W-1:0] term_i,
  output logic [W-1:0] count_o,
  output logic         hit_o
);

  logic [W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clear_i)       count_d = '0;
    else if (enable_i) count_d = count_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) count_q <= '0;
    else        count_q <= count_d;
  end

  assign count_o = count_q;
  assign hit_o   = (count_q == term_i);

endmodule

// File: rtl/spi_slave_ctrl_fsm.sv
// SPI slave control FSM: command frame (address + R/W), then data frames.
// Define SPI_SLAVE_BURST_EN to build the auto-increment burst path (INC state).
module spi_slave_ctrl_fsm
  import spi_ctrl_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int RD_LAT = DEF_RD_LAT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic cs_n,
  input  logic sclk_pe,
  input  logic mosi,
  output logic addr_we,
  output logic sr_we,
  output logic dm_we,
  output logic miso_oe,
  output logic addr_inc,
  output logic busy,
  output logic frame_err
);

  localparam int CNT_W = cnt_width(ADDR_W, DATA_W);
  localparam logic [LAT_W-1:0] LAT_TERM = LAT_W'((RD_LAT == 0) ? 0 : RD_LAT - 1);
  // With zero read latency the wait state is skipped entirely.
  localparam state_e RD_ENTRY = (RD_LAT == 0) ? ST_RD_LOAD : ST_RD_WAIT;
`ifdef SPI_SLAVE_BURST_EN
  localparam state_e FRAME_END = ST_INC;
`else
  localparam state_e FRAME_END = ST_DONE;
`endif

  state_e             state_q, state_d;
  logic               rw_q, rw_d;
  logic               edge_seen_q, edge_seen_d;
  logic [LAT_W-1:0]   lat_q, lat_d;
  logic               frame_err_d;
  logic               miso_d;
  logic               addr_we_q, sr_we_q, dm_we_q, miso_oe_q, busy_q, frame_err_q;

  logic               counting;
  logic               cnt_en, cnt_clr, cnt_hit;
  logic [CNT_W-1:0]   cnt, cnt_term;

  assign counting = (state_q == ST_CMD) || (state_q == ST_RD_SHIFT) ||
                    (state_q == ST_WR_SHIFT);
  assign cnt_en   = sclk_pe && !cs_n && counting;
  assign cnt_clr  = (state_d != state_q);
  assign cnt_term = (state_q == ST_CMD) ? CNT_W'(ADDR_W) : CNT_W'(DATA_W - 1);

  spi_bit_counter #(.W(CNT_W)) u_bit_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear_i  (cnt_clr),
    .enable_i (cnt_en),
    .term_i   (cnt_term),
    .count_o  (cnt),
    .hit_o    (cnt_hit)
  );

`ifdef SPI_SLAVE_BURST_EN
  logic burst_q, burst_d;
  logic addr_inc_q;
`endif

  always_comb begin
    state_d = state_q;
    rw_d    = rw_q;
    // Deselect wins over everything, including a same-cycle sclk edge.
    if (cs_n && (state_q != ST_IDLE)) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE:      if (!cs_n) state_d = ST_CMD;
        ST_CMD: begin
          if (sclk_pe && cnt_hit) begin
            rw_d    = mosi;
            state_d = mosi ? RD_ENTRY : ST_WR_SHIFT;
          end
        end
        ST_RD_WAIT:   if (lat_q == LAT_TERM) state_d = ST_RD_LOAD;
        ST_RD_LOAD:   state_d = ST_RD_SHIFT;
        ST_RD_SHIFT:  if (sclk_pe && cnt_hit) state_d = FRAME_END;
        ST_WR_SHIFT:  if (sclk_pe && cnt_hit) state_d = ST_WR_COMMIT;
        ST_WR_COMMIT: state_d = FRAME_END;
`ifdef SPI_SLAVE_BURST_EN
        ST_INC:       state_d = rw_q ? RD_ENTRY : ST_WR_SHIFT;
`endif
        ST_DONE:      state_d = ST_DONE;
        default:      state_d = ST_IDLE;
      endcase
    end

    lat_d = (state_d != state_q) ? '0 :
            (state_q == ST_RD_WAIT) ? lat_q + 1'b1 : lat_q;

    edge_seen_d = (state_d == ST_IDLE) ? 1'b0 : (edge_seen_q || cnt_en);

    // A partial frame, or an empty one following earlier edges, is an abort.
    frame_err_d = cs_n && (
                    (counting && (cnt != '0)) ||
                    (((state_q == ST_CMD) || (state_q == ST_WR_SHIFT)) && edge_seen_q));

`ifdef SPI_SLAVE_BURST_EN
    burst_d = (state_d == ST_IDLE) ? 1'b0 : (burst_q || (state_q == ST_INC));
    miso_d  = (state_d == ST_RD_SHIFT) ||
              ((state_d == ST_INC) && rw_q) ||
              (((state_d == ST_RD_WAIT) || (state_d == ST_RD_LOAD)) && burst_d);
`else
    miso_d  = (state_d == ST_RD_SHIFT);
`endif
  end

  // Outputs are decoded from the next state so they align with state_q.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      rw_q        <= 1'b0;
      lat_q       <= '0;
      edge_seen_q <= 1'b0;
      addr_we_q   <= 1'b0;
      sr_we_q     <= 1'b0;
      dm_we_q     <= 1'b0;
      miso_oe_q   <= 1'b0;
      busy_q      <= 1'b0;
      frame_err_q <= 1'b0;
`ifdef SPI_SLAVE_BURST_EN
      burst_q     <= 1'b0;
      addr_inc_q  <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      rw_q        <= rw_d;
      lat_q       <= lat_d;
      edge_seen_q <= edge_seen_d;
      addr_we_q   <= (state_d == ST_CMD);
      sr_we_q     <= (state_d == ST_RD_LOAD);
      dm_we_q     <= (state_d == ST_WR_COMMIT);
      miso_oe_q   <= miso_d;
      busy_q      <= (state_d != ST_IDLE);
      frame_err_q <= frame_err_d;
`ifdef SPI_SLAVE_BURST_EN
      burst_q     <= burst_d;
      addr_inc_q  <= (state_d == ST_INC);
`endif
    end
  end

  assign addr_we   = addr_we_q;
  assign sr_we     = sr_we_q;
  assign dm_we     = dm_we_q;
  assign miso_oe   = miso_oe_q;
  assign busy      = busy_q;
  assign frame_err = frame_err_q;
`ifdef SPI_SLAVE_BURST_EN
  assign addr_inc  = addr_inc_q;
`else
  assign addr_inc  = 1'b0;
`endif

endmodule

// File: tb/tb_spi_slave_ctrl_fsm.sv
// Directed bench for spi_slave_ctrl_fsm (ADDR_W=7, DATA_W=8, RD_LAT=1).
// Burst checks follow SPI_SLAVE_BURST_EN, matching the DUT build.
module tb_spi_slave_ctrl_fsm;

  logic clk = 1'b0;
  logic rst_n = 1'b0, cs_n = 1'b1, sclk_pe = 1'b0, mosi = 1'b0;
  logic addr_we, sr_we, dm_we, miso_oe, addr_inc, busy, frame_err;
  int total = 0, bad = 0;
  int dm_cnt = 0, inc_cnt = 0, sr_cnt = 0, fe_cnt = 0;

  always #5 clk = ~clk;

  spi_slave_ctrl_fsm #(.ADDR_W(7), .DATA_W(8), .RD_LAT(1)) dut (
    .clk(clk), .rst_n(rst_n), .cs_n(cs_n), .sclk_pe(sclk_pe), .mosi(mosi),
    .addr_we(addr_we), .sr_we(sr_we), .dm_we(dm_we), .miso_oe(miso_oe),
    .addr_inc(addr_inc), .busy(busy), .frame_err(frame_err)
  );

  // Pulse tallies, sampled mid-cycle.
  always @(negedge clk) begin
    if (dm_we)     dm_cnt  <= dm_cnt + 1;
    if (addr_inc)  inc_cnt <= inc_cnt + 1;
    if (sr_we)     sr_cnt  <= sr_cnt + 1;
    if (frame_err) fe_cnt  <= fe_cnt + 1;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse(input logic b);
    mosi = b; sclk_pe = 1'b1;
    tick(1);
    sclk_pe = 1'b0;
  endtask

  task automatic gap();
    tick(5);
  endtask

  task automatic send_cmd(input logic [6:0] addr, input logic rw);
    cs_n = 1'b0;
    tick(1);
    total++;
    if ({busy, addr_we} !== 2'b11) begin
      bad++; $display("FAIL cmd_entry: busy,addr_we=%b required 11", {busy, addr_we});
    end
    for (int i = 6; i >= 0; i--) begin
      pulse(addr[i]);
      total++;
      if (addr_we !== 1'b1) begin
        bad++; $display("FAIL cmd_addr_we bit%0d: got %b required 1", i, addr_we);
      end
      gap();
    end
    pulse(rw);
    total++;
    if (addr_we !== 1'b0) begin
      bad++; $display("FAIL cmd_rw_addr_we: got %b required 0", addr_we);
    end
  endtask

  task automatic write_frame(input logic [6:0] addr, input logic [7:0] data);
    int dm0, fe0;
    dm0 = dm_cnt; fe0 = fe_cnt;
    send_cmd(addr, 1'b0);
    gap();
    for (int i = 7; i >= 1; i--) begin
      pulse(data[i]);
      total++;
      if (dm_we !== 1'b0) begin
        bad++; $display("FAIL wr_early_dm_we bit%0d: got %b required 0", i, dm_we);
      end
      gap();
    end
    pulse(data[0]);
    total++;
    if (dm_we !== 1'b1) begin
      bad++; $display("FAIL wr_dm_we_pulse: got %b required 1", dm_we);
    end
    tick(1);
    total++;
    if ({dm_we, busy} !== 2'b01) begin
      bad++; $display("FAIL wr_after_commit: dm_we,busy=%b required 01", {dm_we, busy});
    end
    cs_n = 1'b1;
    tick(1);
    total++;
    if (busy !== 1'b0) begin
      bad++; $display("FAIL wr_busy_drop: got %b required 0", busy);
    end
    total++;
    if ((dm_cnt - dm0) != 1 || (fe_cnt - fe0) != 0) begin
      bad++; $display("FAIL wr_counts: dm=%0d fe=%0d required dm=1 fe=0", dm_cnt - dm0, fe_cnt - fe0);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick(2);
    total++;
    if ({addr_we, sr_we, dm_we, miso_oe, addr_inc, busy, frame_err} !== 7'b0) begin
      bad++; $display("FAIL reset_outputs: got %b required 0000000",
                      {addr_we, sr_we, dm_we, miso_oe, addr_inc, busy, frame_err});
    end
    rst_n = 1'b1;
    tick(2);
    total++;
    if (busy !== 1'b0) begin
      bad++; $display("FAIL reset_idle_busy: got %b required 0", busy);
    end
  endtask

  task automatic test_write();
    write_frame(7'h12, 8'hA5);
  endtask

  task automatic test_read();
    int sr0, dm0, fe0;
    logic exp_oe_end;
`ifdef SPI_SLAVE_BURST_EN
    exp_oe_end = 1'b1;
`else
    exp_oe_end = 1'b0;
`endif
    sr0 = sr_cnt; dm0 = dm_cnt; fe0 = fe_cnt;
    send_cmd(7'h12, 1'b1);
    total++;
    if ({sr_we, miso_oe} !== 2'b00) begin
      bad++; $display("FAIL rd_wait: sr_we,miso_oe=%b required 00", {sr_we, miso_oe});
    end
    tick(1);
    total++;
    if ({sr_we, miso_oe} !== 2'b10) begin
      bad++; $display("FAIL rd_load: sr_we,miso_oe=%b required 10", {sr_we, miso_oe});
    end
    tick(1);
    total++;
    if ({sr_we, miso_oe} !== 2'b01) begin
      bad++; $display("FAIL rd_shift_entry: sr_we,miso_oe=%b required 01", {sr_we, miso_oe});
    end
    tick(3);
    for (int i = 1; i <= 7; i++) begin
      pulse(1'b0);
      total++;
      if (miso_oe !== 1'b1) begin
        bad++; $display("FAIL rd_miso_oe edge%0d: got %b required 1", i, miso_oe);
      end
      gap();
    end
    pulse(1'b0);
    total++;
    if (miso_oe !== exp_oe_end) begin
      bad++; $display("FAIL rd_miso_oe_end: got %b required %b", miso_oe, exp_oe_end);
    end
    cs_n = 1'b1;
    tick(1);
    total++;
    if ((sr_cnt - sr0) != 1 || (dm_cnt - dm0) != 0 || (fe_cnt - fe0) != 0 || busy !== 1'b0) begin
      bad++; $display("FAIL rd_counts: sr=%0d dm=%0d fe=%0d busy=%b required 1 0 0 0",
                      sr_cnt - sr0, dm_cnt - dm0, fe_cnt - fe0, busy);
    end
  endtask

  task automatic test_abort();
    int dm0, fe0;
    dm0 = dm_cnt; fe0 = fe_cnt;
    send_cmd(7'h12, 1'b0);
    gap();
    for (int i = 0; i < 3; i++) begin
      pulse(1'b1);
      gap();
    end
    cs_n = 1'b1;
    tick(1);
    total++;
    if ({busy, frame_err} !== 2'b01) begin
      bad++; $display("FAIL abort_idle: busy,frame_err=%b required 01", {busy, frame_err});
    end
    tick(1);
    total++;
    if (frame_err !== 1'b0) begin
      bad++; $display("FAIL abort_err_width: got %b required 0", frame_err);
    end
    total++;
    if ((dm_cnt - dm0) != 0 || (fe_cnt - fe0) != 1) begin
      bad++; $display("FAIL abort_counts: dm=%0d fe=%0d required dm=0 fe=1", dm_cnt - dm0, fe_cnt - fe0);
    end
    write_frame(7'h33, 8'h5A);
  endtask

`ifdef SPI_SLAVE_BURST_EN
  task automatic test_burst();
    int dm0, inc0, fe0;
    dm0 = dm_cnt; inc0 = inc_cnt; fe0 = fe_cnt;
    send_cmd(7'h12, 1'b0);
    gap();
    for (int f = 0; f < 3; f++) begin
      for (int i = 0; i < 7; i++) begin
        pulse(1'b1);
        gap();
      end
      pulse(1'b0);
      total++;
      if ({dm_we, addr_inc} !== 2'b10) begin
        bad++; $display("FAIL burst_commit f%0d: dm_we,addr_inc=%b required 10", f, {dm_we, addr_inc});
      end
      tick(1);
      total++;
      if ({dm_we, addr_inc} !== 2'b01) begin
        bad++; $display("FAIL burst_inc f%0d: dm_we,addr_inc=%b required 01", f, {dm_we, addr_inc});
      end
      tick(1);
      total++;
      if (addr_inc !== 1'b0) begin
        bad++; $display("FAIL burst_inc_width f%0d: got %b required 0", f, addr_inc);
      end
      tick(3);
    end
    cs_n = 1'b1;
    tick(1);
    // Deselect in an empty WR_SHIFT after earlier edges counts as an abort.
    total++;
    if ((dm_cnt - dm0) != 3 || (inc_cnt - inc0) != 3 || (fe_cnt - fe0) != 1) begin
      bad++; $display("FAIL burst_counts: dm=%0d inc=%0d fe=%0d required 3 3 1",
                      dm_cnt - dm0, inc_cnt - inc0, fe_cnt - fe0);
    end
  endtask
`else
  task automatic test_no_burst();
    int dm0, inc0, fe0;
    dm0 = dm_cnt; inc0 = inc_cnt; fe0 = fe_cnt;
    send_cmd(7'h12, 1'b0);
    gap();
    for (int i = 0; i < 16; i++) begin
      pulse(i[0]);
      gap();
    end
    total++;
    if ((dm_cnt - dm0) != 1 || (inc_cnt - inc0) != 0 || busy !== 1'b1) begin
      bad++; $display("FAIL noburst_counts: dm=%0d inc=%0d busy=%b required 1 0 1",
                      dm_cnt - dm0, inc_cnt - inc0, busy);
    end
    cs_n = 1'b1;
    tick(1);
    total++;
    if ((fe_cnt - fe0) != 0 || busy !== 1'b0) begin
      bad++; $display("FAIL noburst_done_exit: fe=%0d busy=%b required 0 0", fe_cnt - fe0, busy);
    end
  endtask
`endif

  task automatic test_back_to_back();
    write_frame(7'h01, 8'hFF);
    write_frame(7'h7F, 8'h00);
  endtask

  task automatic test_async_reset();
    send_cmd(7'h12, 1'b1);
    tick(4);
    pulse(1'b1);
    gap();
    pulse(1'b1);
    total++;
    if (miso_oe !== 1'b1) begin
      bad++; $display("FAIL arst_pre_miso_oe: got %b required 1", miso_oe);
    end
    #3 rst_n = 1'b0;
    #1;
    total++;
    if ({addr_we, sr_we, dm_we, miso_oe, addr_inc, busy, frame_err} !== 7'b0) begin
      bad++; $display("FAIL arst_outputs: got %b required 0000000",
                      {addr_we, sr_we, dm_we, miso_oe, addr_inc, busy, frame_err});
    end
    cs_n = 1'b1;
    #2 rst_n = 1'b1;
    tick(2);
    total++;
    if ({busy, miso_oe, frame_err} !== 3'b000) begin
      bad++; $display("FAIL arst_release: busy,miso_oe,frame_err=%b required 000", {busy, miso_oe, frame_err});
    end
    write_frame(7'h12, 8'h3C);
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_abort();
`ifdef SPI_SLAVE_BURST_EN
    test_burst();
`else
    test_no_burst();
`endif
    test_back_to_back();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
